// File: rtl/nano_gpu_pkg.sv
// Shared frame-buffer geometry and state encoding for the nano GPU.
package nano_gpu_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int PIX_W     = 8;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = $clog2(FB_PIXELS);
    localparam int X_W       = $clog2(FB_WIDTH);
    localparam int Y_W       = $clog2(FB_HEIGHT);

    typedef enum logic {
        FB_IDLE,
        FB_CLEAR
    } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// One frame-buffer bank: simple dual-port RAM, synchronous write, registered read.
module fb_bank #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_db.sv
// Double-buffered frame buffer: draw into the back bank, scan out the front bank,
// swap in vblank on request, with a one-pixel-per-cycle clear engine.
module frame_buffer_db #(
    parameter int FB_WIDTH  = nano_gpu_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = nano_gpu_pkg::FB_HEIGHT,
    parameter int PIX_W     = nano_gpu_pkg::PIX_W,
    parameter int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int X_W       = $clog2(FB_WIDTH),
    parameter int Y_W       = $clog2(FB_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_color,
    output logic              clear_busy,
    input  logic              swap_req,
    input  logic              vblank,
    output logic              swap_done,
    output logic              front_bank
);

    localparam int                FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    nano_gpu_pkg::fb_state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              front_q, front_d;
    logic              pending_q, pending_d;
    logic              swap_done_q, swap_done_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_ok_q, rd_ok_d;

    logic [ADDR_W-1:0] wr_addr, bank_waddr;
    logic [PIX_W-1:0]  bank_wdata, bank0_rdata, bank1_rdata;
    logic              wr_in_range, bank_we, swap_exec;

    assign wr_ready   = rst_n && (state_q == nano_gpu_pkg::FB_IDLE);
    assign clear_busy = (state_q == nano_gpu_pkg::FB_CLEAR);
    assign swap_done  = swap_done_q;
    assign front_bank = front_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        bank_we     = 1'b0;
        bank_waddr  = '0;
        bank_wdata  = '0;
        wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(wr_x);
        wr_in_range = (32'(wr_x) < FB_WIDTH) && (32'(wr_y) < FB_HEIGHT);
        swap_exec   = pending_q && vblank && (state_q == nano_gpu_pkg::FB_IDLE);

        case (state_q)
            nano_gpu_pkg::FB_IDLE: begin
                // Out-of-range coordinates are accepted but never reach the RAM.
                bank_we    = wr_valid && wr_ready && wr_in_range;
                bank_waddr = wr_addr;
                bank_wdata = wr_data;
                if (clear_start) begin
                    state_d = nano_gpu_pkg::FB_CLEAR;
                    color_d = clear_color;
                    cnt_d   = '0;
                end
            end
            nano_gpu_pkg::FB_CLEAR: begin
                bank_we    = 1'b1;
                bank_waddr = cnt_q;
                bank_wdata = color_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = nano_gpu_pkg::FB_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = nano_gpu_pkg::FB_IDLE;
        endcase

        // A request on the swap edge itself re-arms for the next vblank.
        front_d     = swap_exec ? ~front_q : front_q;
        pending_d   = swap_req || (pending_q && !swap_exec);
        swap_done_d = swap_exec;
        rd_sel_d    = front_q;
        rd_ok_d     = 32'(rd_addr) < FB_PIXELS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= nano_gpu_pkg::FB_IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            front_q     <= front_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
            rd_sel_q    <= rd_sel_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    // Bank select is delayed alongside the RAM read so data and select stay paired.
    assign rd_data = rd_ok_q ? (rd_sel_q ? bank1_rdata : bank0_rdata) : '0;

    fb_bank #(
        .DEPTH (FB_PIXELS),
        .AW    (ADDR_W),
        .DW    (PIX_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (bank_we && front_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank0_rdata)
    );

    fb_bank #(
        .DEPTH (FB_PIXELS),
        .AW    (ADDR_W),
        .DW    (PIX_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (bank_we && !front_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank1_rdata)
    );

endmodule

// File: doc/frame_buffer_db.md
Name: frame_buffer_db

Overview:
Parametrised double-buffered frame buffer. It replaces the single-bank 320x240x8 frame buffer.
- The draw side writes pixels by (x,y) into the back bank.
- The scanout side reads the front bank by linear address.
- Banks swap only during vertical blank, on request.
- A hardware clear engine fills the back bank with a constant colour, one pixel per cycle.

Parameters:
FB_WIDTH, 320, pixels per line
FB_HEIGHT, 240, lines per frame
PIX_W, 8, bits per pixel
ADDR_W, $clog2(FB_WIDTH*FB_HEIGHT) (17), linear address width
X_W, $clog2(FB_WIDTH) (9), x coordinate width
Y_W, $clog2(FB_HEIGHT) (8), y coordinate width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  draw-side pixel write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_x  in  X_W  pixel x
wr_y  in  Y_W  pixel y
wr_data  in  PIX_W  pixel colour
rd_addr  in  ADDR_W  scanout linear address (y*FB_WIDTH+x)
rd_data  out  PIX_W  front-bank pixel, 1-cycle latency
clear_start  in  1  pulse: start clearing back bank
clear_color  in  PIX_W  fill colour, sampled on clear_start
clear_busy  out  1  clear engine active
swap_req  in  1  pulse: request front/back swap
vblank  in  1  vertical blank from display timing
swap_done  out  1  one-cycle pulse, the cycle after the swap takes effect
front_bank  out  1  index of the bank being scanned out

Behaviour:
- Reset values:
  - front_bank=0, so bank1 is the back bank.
  - rd_data=0, wr_ready=0 while rst_n low, clear_busy=0, swap_done=0, swap_pending=0.
  - FSM=IDLE, clear counter=0.
  - RAM contents are not reset.
- Read path:
  - rd_data at edge N+1 holds bank[front_bank][rd_addr] as sampled at edge N.
  - Reads run every cycle; there is no enable.
  - rd_addr >= FB_WIDTH*FB_HEIGHT returns 0.
- Write path:
  - Address is wr_y*FB_WIDTH+wr_x, computed at ADDR_W width.
  - A write is committed to the back bank on the accepting edge.
  - wr_ready=1 in IDLE and 0 in CLEAR.
  - If wr_x>=FB_WIDTH or wr_y>=FB_HEIGHT, the write is accepted but dropped, with no aliasing.
- FSM IDLE:
  - clear_start moves the FSM to CLEAR.
  - clear_color is latched and the counter set to 0.
- FSM CLEAR:
  - Each cycle, clear_color is written to the back bank at the counter address, then the counter increments.
  - When counter == FB_WIDTH*FB_HEIGHT-1, that final write happens and the FSM returns to IDLE.
  - The clear takes exactly FB_WIDTH*FB_HEIGHT cycles; clear_busy is high for exactly that many cycles.
  - clear_start during CLEAR is ignored.
- Swap:
  - swap_req sets swap_pending; further requests while pending merge into one.
  - The swap executes on an edge where swap_pending && vblank && FSM==IDLE.
  - On that edge front_bank toggles and swap_pending clears; swap_done is high the following cycle.
  - A swap_req arriving on the same edge a swap executes is not lost; it re-arms swap_pending.
  - A swap requested during CLEAR waits for the clear to complete.
- Simultaneous events:
  - A write accepted on the swap edge goes to the pre-swap back bank.
  - A read sampled on the swap edge uses the pre-swap front bank.
  - clear_start and swap_req together in IDLE: the clear starts and the swap is deferred until it completes.
- Reset mid-clear: the clear aborts immediately, all state returns to reset values, and partially cleared contents are retained.

Decomposition:
- Shared package nano_gpu_pkg holds:
  - FB_WIDTH, FB_HEIGHT, PIX_W;
  - the derived ADDR_W, X_W, Y_W;
  - the state enum fb_state_t {FB_IDLE, FB_CLEAR}.
- Sub-module fb_bank: simple dual-port RAM with one synchronous write port, one registered read port and inferable memory. It is instantiated twice.
- Bank write-select is ~front_bank. Read mux: front_bank selects between the two bank outputs, registered once.

Test Plan:
1. Clear the back bank to 0x00, write (0,0)=0xFF, (1,1)=0xAA and (319,239)=0x55, then swap at vblank. Reading addresses 0, 321 and 76799 must return 0xFF, 0xAA and 0x55, each one cycle after its address.
2. clear_start with colour 0x1C:
   - clear_busy and wr_ready must be low for exactly 76800 cycles.
   - After the swap, addresses 0, 38400 and 76799 must read 0x1C.
3. swap_req with vblank=0 held for 100 cycles must leave front_bank unchanged with no swap_done. Raising vblank must toggle front_bank on the next edge, with swap_done pulsing once the cycle after.
4. Out-of-range write x=320,y=0 with data 0x77 must be accepted (wr_ready=1) and dropped. After the swap, address 320 must retain its prior value and not read 0x77.
5. swap_req during an active clear with vblank held high must produce no swap until clear_busy falls. The swap must then occur on the first IDLE edge.
6. Asserting rst_n=0 mid-clear (counter around 1000) must drop clear_busy immediately, and front_bank must be 0. After release, wr_ready=1 and subsequent writes and reads must function normally.
